// File: rtl/mult_defs_pkg.sv
// Shared definitions for the sequential 4x4 multiplier.
//   WIDTH : operand width (matches the 4-bit ripple adder)
//   ITERS : add/shift iterations per multiply
//   state_t : FSM state encoding (IDLE=0, CALC=1, DONE=2; 3 is unused)
package mult_defs;

    localparam int WIDTH = 4;
    localparam int ITERS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder4.sv
// 4-bit ripple-carry adder.
//   a, b : addends
//   cin  : carry in
//   sum  : 4-bit sum
//   cout : carry out of the top bit
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[4];

endmodule

// File: rtl/mult4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request a multiply (only honoured in IDLE)
//   a, b    : multiplicand / multiplier, captured on an accepted start
//   busy    : high during the four CALC cycles
//   done    : one-cycle completion pulse
//   product : 8-bit result, held until the next completion
module mult4_seq
    import mult_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    state_t               state_reg,   state_next;
    logic [WIDTH-1:0]     mcand_reg,   mcand_next;
    logic [2*WIDTH-1:0]   acc_reg,     acc_next;
    logic [1:0]           cnt_reg,     cnt_next;
    logic [2*WIDTH-1:0]   product_reg, product_next;

    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;

    // Partial sum (upper half of acc) plus the multiplicand.
    adder4 u_adder (
        .a    (acc_reg[2*WIDTH-1:WIDTH]),
        .b    (mcand_reg),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_next   = state_reg;
        mcand_next   = mcand_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    mcand_next = a;
                    acc_next   = {{WIDTH{1'b0}}, b};
                    cnt_next   = 2'd0;
                    state_next = CALC;
                end
            end
            CALC: begin
                // The adder carry lands in acc[7]; the consumed multiplier
                // bit falls off the bottom as the whole register shifts right.
                if (acc_reg[0]) begin
                    acc_next = {add_cout, add_sum, acc_reg[WIDTH-1:1]};
                end else begin
                    acc_next = {1'b0, acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1:1]};
                end
                cnt_next = cnt_reg + 2'd1;
                if (cnt_reg == 2'(ITERS - 1)) begin
                    product_next = acc_next;
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                // Unused encoding recovers to IDLE.
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    // Decoded straight from the state register: no input-to-output path.
    assign busy    = (state_reg == CALC);
    assign done    = (state_reg == DONE);
    assign product = product_reg;

endmodule
